// File: rtl/axicb_txn_scheduler_if.sv
// Request/grant bus between requesters and the transaction scheduler.
interface axicb_txn_scheduler_if #(
  parameter int unsigned REQ_NB = 4
);
  logic [REQ_NB-1:0] req;
  logic              ack;
  logic              done;
  logic [REQ_NB-1:0] grant;
  logic [1:0]        grant_idx;
  logic [7:0]        ostdg_cnt;
  logic              timeout;
  logic              underflow;

  // Requester side: drives requests and handshake/completion events.
  modport master (
    output req, ack, done,
    input  grant, grant_idx, ostdg_cnt, timeout, underflow
  );

  // Scheduler side.
  modport slave (
    input  req, ack, done,
    output grant, grant_idx, ostdg_cnt, timeout, underflow
  );
endinterface

// File: rtl/axicb_txn_scheduler.sv
// Priority/round-robin transaction scheduler with outstanding-count limit
// and grant watchdog.
module axicb_txn_scheduler #(
  parameter int unsigned REQ_NB         = 4,
  parameter logic [1:0]  REQ0_PRIORITY  = 2'd0,
  parameter logic [1:0]  REQ1_PRIORITY  = 2'd0,
  parameter logic [1:0]  REQ2_PRIORITY  = 2'd0,
  parameter logic [1:0]  REQ3_PRIORITY  = 2'd0,
  parameter int unsigned MAX_OSTDG      = 8,
  parameter bit          TIMEOUT_ENABLE = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  axicb_txn_scheduler_if.slave  bus
);

  localparam logic [7:0] CNT_MAX  = 8'(MAX_OSTDG);
  localparam logic [1:0] IDX_INIT = 2'(REQ_NB - 1);
  localparam logic [1:0] PRIO [4] = '{REQ0_PRIORITY, REQ1_PRIORITY,
                                      REQ2_PRIORITY, REQ3_PRIORITY};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q;
  logic [REQ_NB-1:0] grant_q;
  logic [1:0]        grant_idx_q;
  logic [7:0]        ostdg_cnt_q;
  logic              timeout_q;
  logic              underflow_q;

  logic [1:0]        max_prio_c;
  logic [1:0]        cand_c;
  logic [1:0]        win_idx_c;
  logic              win_found_c;
  logic              ack_acc_c;
  logic              expire_c;

  // Only an ack seen while a grant is held counts as an accepted handshake.
  assign ack_acc_c = bus.ack && (state_q == GRANT);

  // Winner: highest asserted priority, ties scanned from grant_idx+1 onward.
  always_comb begin
    max_prio_c  = 2'd0;
    cand_c      = 2'd0;
    win_idx_c   = grant_idx_q;
    win_found_c = 1'b0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (bus.req[i] && (PRIO[i] > max_prio_c)) max_prio_c = PRIO[i];
    end
    for (int unsigned k = 1; k <= REQ_NB; k++) begin
      cand_c = 2'((32'(grant_idx_q) + k) % REQ_NB);
      if (!win_found_c && bus.req[cand_c] && (PRIO[cand_c] == max_prio_c)) begin
        win_idx_c   = cand_c;
        win_found_c = 1'b1;
      end
    end
  end

  generate
    if (TIMEOUT_ENABLE) begin : g_wd
      localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [WD_W-1:0] wd_q;

      assign expire_c = (state_q == GRANT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

      // Watchdog counts GRANT cycles without ack; idle forces it back to zero.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wd_q <= '0;
        end else if (srst) begin
          wd_q <= '0;
        end else if ((state_q == GRANT) && !bus.ack && !expire_c) begin
          wd_q <= wd_q + WD_W'(1);
        end else begin
          wd_q <= '0;
        end
      end
    end else begin : g_no_wd
      assign expire_c = 1'b0;
    end
  endgenerate

  // Grant FSM, outstanding counter and event pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= IDX_INIT;
      ostdg_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else if (srst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= IDX_INIT;
      ostdg_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      timeout_q   <= 1'b0;
      underflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|bus.req) && (ostdg_cnt_q < CNT_MAX) && win_found_c) begin
            state_q     <= GRANT;
            grant_q     <= REQ_NB'(1) << win_idx_c;
            grant_idx_q <= win_idx_c;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            state_q <= IDLE;
            grant_q <= '0;
          end else if (expire_c) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase

      if (ack_acc_c && !bus.done) begin
        if (ostdg_cnt_q < CNT_MAX) ostdg_cnt_q <= ostdg_cnt_q + 8'd1;
      end else if (bus.done && !ack_acc_c) begin
        if (ostdg_cnt_q != 8'd0) ostdg_cnt_q <= ostdg_cnt_q - 8'd1;
        else                     underflow_q <= 1'b1;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.ostdg_cnt = ostdg_cnt_q;
  assign bus.timeout   = timeout_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_axicb_txn_scheduler.sv
// Directed bench for axicb_txn_scheduler: default, priority and
// limit/watchdog configurations driven from shared stimulus.
module tb_axicb_txn_scheduler;

  logic       aclk;
  logic       aresetn;
  logic       srst;
  logic [3:0] req;
  logic       ack;
  logic       done;
  int         sel;
  int         tests;
  int         fails;

  logic [3:0] o_grant;
  logic [1:0] o_idx;
  logic [7:0] o_cnt;
  logic       o_to;
  logic       o_uf;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       uf;
  } vec_t;

  vec_t       vec [24];
  logic [3:0] rr_g [4];
  logic [1:0] rr_i [4];

  axicb_txn_scheduler_if #(.REQ_NB(4)) if_a ();
  axicb_txn_scheduler_if #(.REQ_NB(4)) if_b ();
  axicb_txn_scheduler_if #(.REQ_NB(4)) if_c ();

  assign if_a.req = req;  assign if_a.ack = ack;  assign if_a.done = done;
  assign if_b.req = req;  assign if_b.ack = ack;  assign if_b.done = done;
  assign if_c.req = req;  assign if_c.ack = ack;  assign if_c.done = done;

  axicb_txn_scheduler u_a (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(if_a.slave)
  );
  axicb_txn_scheduler #(.REQ2_PRIORITY(2'd3)) u_b (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(if_b.slave)
  );
  axicb_txn_scheduler #(.MAX_OSTDG(2), .TIMEOUT_CYCLES(4)) u_c (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(if_c.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    o_grant = if_a.grant; o_idx = if_a.grant_idx; o_cnt = if_a.ostdg_cnt;
    o_to    = if_a.timeout; o_uf = if_a.underflow;
    if (sel == 1) begin
      o_grant = if_b.grant; o_idx = if_b.grant_idx; o_cnt = if_b.ostdg_cnt;
      o_to    = if_b.timeout; o_uf = if_b.underflow;
    end else if (sel == 2) begin
      o_grant = if_c.grant; o_idx = if_c.grant_idx; o_cnt = if_c.ostdg_cnt;
      o_to    = if_c.timeout; o_uf = if_c.underflow;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drv(input logic [3:0] r, input logic a, input logic d);
    req  = r;
    ack  = a;
    done = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g, input logic [1:0] ix,
                         input logic [7:0] c, input logic t, input logic u);
    chk({nm, " grant"},     32'(o_grant), 32'(g));
    chk({nm, " grant_idx"}, 32'(o_idx),   32'(ix));
    chk({nm, " ostdg_cnt"}, 32'(o_cnt),   32'(c));
    chk({nm, " timeout"},   32'(o_to),    32'(t));
    chk({nm, " underflow"}, 32'(o_uf),    32'(u));
  endtask

  task automatic sync_reset();
    srst = 1'b1;
    drv(4'b0000, 1'b0, 1'b0);
    tick();
    srst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin
    tests   = 0;
    fails   = 0;
    sel     = 0;
    aresetn = 1'b0;
    srst    = 1'b0;
    drv(4'b0000, 1'b0, 1'b0);

    // Default configuration: round-robin, counting, underflow, idle acks.
    vec[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 8'd0, 1'b0};
    vec[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 8'd1, 1'b0};
    vec[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 8'd1, 1'b0};
    vec[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 8'd2, 1'b0};
    vec[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 8'd2, 1'b0};
    vec[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2, 8'd3, 1'b0};
    vec[6]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 8'd3, 1'b0};
    vec[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3, 8'd4, 1'b0};
    vec[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 8'd4, 1'b0};
    vec[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 8'd5, 1'b0};
    vec[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 8'd4, 1'b0};
    vec[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 8'd3, 1'b0};
    vec[12] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 8'd3, 1'b0};
    vec[13] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, 8'd3, 1'b0};
    vec[14] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd2, 1'b0};
    vec[15] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd1, 1'b0};
    vec[16] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd0, 1'b0};
    vec[17] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd0, 1'b1};
    vec[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 8'd0, 1'b0};
    vec[19] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 8'd0, 1'b0};
    vec[20] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 8'd0, 1'b0};
    vec[21] = '{4'b1000, 1'b0, 1'b0, 4'b0010, 2'd1, 8'd0, 1'b0};
    vec[22] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 8'd1, 1'b0};
    vec[23] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 2'd1, 8'd0, 1'b0};

    rr_g = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};
    rr_i = '{2'd3, 2'd0, 2'd1, 2'd3};

    #12;
    chk_out("A reset", 4'b0000, 2'd3, 8'd0, 1'b0, 1'b0);
    aresetn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drv(vec[i].req, vec[i].ack, vec[i].done);
      tick();
      chk_out($sformatf("A row%0d", i), vec[i].grant, vec[i].idx, vec[i].cnt, 1'b0, vec[i].uf);
    end

    // Static priority: requester 2 always wins, then round-robin among the rest.
    sel = 1;
    sync_reset();
    chk_out("B srst", 4'b0000, 2'd3, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv(4'b1111, 1'b0, 1'b0);
      tick();
      chk_out($sformatf("B prio%0d", i), 4'b0100, 2'd2, 8'(i), 1'b0, 1'b0);
      drv(4'b1111, 1'b1, 1'b0);
      tick();
      chk_out($sformatf("B prio_ack%0d", i), 4'b0000, 2'd2, 8'(i + 1), 1'b0, 1'b0);
    end
    for (int j = 0; j < 4; j++) begin
      drv(4'b1011, 1'b0, 1'b0);
      tick();
      chk_out($sformatf("B rr%0d", j), rr_g[j], rr_i[j], 8'(3 + j), 1'b0, 1'b0);
      drv(4'b1011, 1'b1, 1'b0);
      tick();
      chk_out($sformatf("B rr_ack%0d", j), 4'b0000, rr_i[j], 8'(4 + j), 1'b0, 1'b0);
    end

    // Watchdog expiry, ack winning at expiry, and outstanding limit.
    sel = 2;
    sync_reset();
    chk_out("C srst", 4'b0000, 2'd3, 8'd0, 1'b0, 1'b0);
    drv(4'b0011, 1'b0, 1'b0);
    tick();
    chk_out("C grant1", 4'b0001, 2'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("C hold%0d", i), 4'b0001, 2'd0, 8'd0, 1'b0, 1'b0);
    end
    tick();
    chk_out("C timeout", 4'b0000, 2'd0, 8'd0, 1'b1, 1'b0);
    tick();
    chk_out("C regrant", 4'b0010, 2'd1, 8'd0, 1'b0, 1'b0);
    drv(4'b0011, 1'b1, 1'b0);
    tick();
    chk_out("C ack1", 4'b0000, 2'd1, 8'd1, 1'b0, 1'b0);
    drv(4'b0011, 1'b0, 1'b0);
    tick();
    chk_out("C grant3", 4'b0001, 2'd0, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("C hold_b%0d", i), 4'b0001, 2'd0, 8'd1, 1'b0, 1'b0);
    end
    drv(4'b0011, 1'b1, 1'b0);
    tick();
    chk_out("C ack_at_expiry", 4'b0000, 2'd0, 8'd2, 1'b0, 1'b0);
    drv(4'b0011, 1'b0, 1'b0);
    tick();
    chk_out("C full1", 4'b0000, 2'd0, 8'd2, 1'b0, 1'b0);
    tick();
    chk_out("C full2", 4'b0000, 2'd0, 8'd2, 1'b0, 1'b0);
    drv(4'b0011, 1'b0, 1'b1);
    tick();
    chk_out("C done_at_full", 4'b0000, 2'd0, 8'd1, 1'b0, 1'b0);
    drv(4'b0011, 1'b0, 1'b0);
    tick();
    chk_out("C freed", 4'b0010, 2'd1, 8'd1, 1'b0, 1'b0);
    drv(4'b0011, 1'b1, 1'b0);
    tick();
    chk_out("C refill", 4'b0000, 2'd1, 8'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant with outstanding transactions.
    sel = 0;
    sync_reset();
    chk_out("A srst", 4'b0000, 2'd3, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drv(4'b0100, 1'b0, 1'b0);
      tick();
      drv(4'b0100, 1'b1, 1'b0);
      tick();
    end
    drv(4'b0100, 1'b0, 1'b0);
    tick();
    chk_out("A pre_async", 4'b0100, 2'd2, 8'd5, 1'b0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    chk_out("A async_rst", 4'b0000, 2'd3, 8'd0, 1'b0, 1'b0);
    #2;
    aresetn = 1'b1;
    drv(4'b1111, 1'b0, 1'b0);
    tick();
    chk_out("A post_rst", 4'b0001, 2'd0, 8'd0, 1'b0, 1'b0);
    drv(4'b0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axicb_txn_scheduler.md
AXICB_TXN_SCHEDULER -- requirements
Module: axicb_txn_scheduler

Interface
REQ-001 Parameter REQ_NB, default 4: number of requesters (1..4).
REQ-002 Parameter REQ0_PRIORITY..REQ3_PRIORITY, default 0: 2-bit static priority per requester; 3 is highest.
REQ-003 Parameter MAX_OSTDG, default 8: maximum outstanding transactions (1..255).
REQ-004 Parameter TIMEOUT_ENABLE, default 1: enables the grant watchdog.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in cycles (>=2).
REQ-006 aclk  in  1  single clock; all state on rising edge.
REQ-007 aresetn  in  1  asynchronous active-low reset.
REQ-008 srst  in  1  synchronous active-high reset, same effect as aresetn.
REQ-009 req  in  REQ_NB  per-requester request (address valid).
REQ-010 ack  in  1  address handshake of the granted requester completed (valid & ready downstream).
REQ-011 done  in  1  one transaction completed (last response beat accepted).
REQ-012 grant  out  REQ_NB  registered one-hot grant, or all zeros.
REQ-013 grant_idx  out  2  index of the current or last grant.
REQ-014 ostdg_cnt  out  8  outstanding transaction count.
REQ-015 timeout  out  1  one-cycle pulse when the watchdog expires.
REQ-016 underflow  out  1  one-cycle pulse when done arrives with ostdg_cnt==0.

Function
REQ-017 The FSM SHALL have two states. IDLE: grant=0. GRANT: grant holds exactly one bit.
REQ-018 IDLE->GRANT SHALL occur when |req && ostdg_cnt<MAX_OSTDG; the grant register loads the winner, so grant appears 1 cycle after req is sampled.
REQ-019 Winner SHALL be taken from the highest priority level among asserted req; ties resolve round-robin, starting at the index after the last accepted grant_idx and wrapping REQ_NB-1->0.
REQ-020 Grant SHALL stay stable in GRANT until ack or timeout, even if req changes.
REQ-021 On ack: GRANT->IDLE; grant_idx becomes the round-robin pointer; ostdg_cnt+1.
REQ-022 After each ack the FSM SHALL pass through IDLE for one cycle (one bubble); back-to-back grants are therefore 2 cycles apart at minimum.
REQ-023 ostdg_cnt SHALL be +1 on ack alone, -1 on done alone, unchanged on ack&&done; it never exceeds MAX_OSTDG and never wraps.
REQ-024 done with ostdg_cnt==0 and no simultaneous ack: count stays 0 and underflow pulses 1 cycle.
REQ-025 With ostdg_cnt==MAX_OSTDG, IDLE SHALL NOT grant; a done in that cycle allows a grant on the next evaluation.
REQ-026 Watchdog (TIMEOUT_ENABLE=1): counter clears on entry to GRANT and increments each GRANT cycle without ack; at TIMEOUT_CYCLES-1 without ack it SHALL pulse timeout, go GRANT->IDLE, set grant_idx to the timed-out index so round-robin skips it, and leave ostdg_cnt unchanged.
REQ-027 ack in the same cycle as expiry SHALL win: normal ack behaviour, no timeout pulse.
REQ-028 TIMEOUT_ENABLE=0: watchdog logic absent; timeout is tied 0.
REQ-029 ack or done while in IDLE SHALL be ignored for FSM and pointer; done still decrements ostdg_cnt.

Reset
REQ-030 On aresetn low (async) or srst high (sync): state IDLE, grant=0, grant_idx=REQ_NB-1 (first tie resolves to index 0), ostdg_cnt=0, watchdog=0, timeout=0, underflow=0.
REQ-031 Reset mid-GRANT SHALL drop grant immediately (async) and discard outstanding count without a done.

Verification
REQ-032 All priorities 0, req=4'b1111, ack 1 cycle after each grant -> grant sequence 0001,0010,0100,1000,0001; ostdg_cnt 1..5.
REQ-033 REQ2_PRIORITY=3, others 0, req=4'b1111 -> grant=0100 every time; req=4'b1011 -> round-robin among 0,1,3.
REQ-034 MAX_OSTDG=2, two acks and no done -> grant stays 0 with req high; one done pulse -> grant 2 cycles later, ostdg_cnt 2->1->2.
REQ-035 TIMEOUT_CYCLES=4, grant=0001 and ack never asserted -> timeout pulse in the 4th GRANT cycle, grant=0, next grant=0010 with req=4'b0011.
REQ-036 ack&&done with ostdg_cnt=3 -> stays 3; done with ostdg_cnt=0 -> underflow=1 for 1 cycle and count stays 0.
REQ-037 aresetn low while grant=0100 and ostdg_cnt=5 -> grant=0 and ostdg_cnt=0 before the next clock edge; after release the first grant goes to index 0.
